// File: rtl/addr_carry_look_ahead_if.sv
// Operand/result bundle for addr_carry_look_ahead; the master drives operands and the slave returns
// the registered result plus the debug vectors.
interface addr_carry_look_ahead_if #(
    parameter int p_WIDTH = 8
);
    logic               iw_valid;
    logic [p_WIDTH-1:0] iwv_x;
    logic [p_WIDTH-1:0] iwv_y;
    logic               iw_carry;
    logic               wo_valid;
    logic [p_WIDTH:0]   wov_carry;
    logic [p_WIDTH:0]   wov_sum;
    logic [p_WIDTH-1:0] wov_cs;
    logic [p_WIDTH:0]   wov_output;

    modport master (
        output iw_valid, iwv_x, iwv_y, iw_carry,
        input  wo_valid, wov_carry, wov_sum, wov_cs, wov_output
    );

    modport slave (
        input  iw_valid, iwv_x, iwv_y, iw_carry,
        output wo_valid, wov_carry, wov_sum, wov_cs, wov_output
    );
endinterface

// File: rtl/addr_carry_look_ahead.sv
// Two-level carry-lookahead adder (4-bit groups + group lookahead) with registered result.
// Define ADDR_CLA_DEBUG_EN to register and expose the carry, half-sum and generate vectors.
module addr_carry_look_ahead #(
    parameter int p_WIDTH = 8
) (
    input  logic                  iw_clk,
    input  logic                  iw_rst_n,
    addr_carry_look_ahead_if.slave bus
);
    localparam int c_NG = (p_WIDTH + 3) / 4;
    localparam int c_WP = c_NG * 4;

    logic [c_WP-1:0]    p_pad;
    logic [c_WP-1:0]    g_pad;
    logic [c_NG-1:0]    grp_p;
    logic [c_NG-1:0]    grp_g;
    logic [c_NG:0]      grp_c;
    logic [p_WIDTH:0]   carry_c;
    logic [p_WIDTH:0]   output_c;

    logic               valid_d, valid_q;
    logic [p_WIDTH:0]   out_d, out_q;

    // Padding bits propagate without generating, so the partial top group's
    // carry-out equals the carry out of bit W-1.
    always_comb begin
        p_pad = '1;
        g_pad = '0;
        p_pad[p_WIDTH-1:0] = bus.iwv_x ^ bus.iwv_y;
        g_pad[p_WIDTH-1:0] = bus.iwv_x & bus.iwv_y;
    end

    always_comb begin
        grp_p = '0;
        grp_g = '0;
        for (int j = 0; j < c_NG; j++) begin
            grp_p[j] = &p_pad[4*j +: 4];
            grp_g[j] = g_pad[4*j+3]
                     | (p_pad[4*j+3] & g_pad[4*j+2])
                     | (p_pad[4*j+3] & p_pad[4*j+2] & g_pad[4*j+1])
                     | ((&p_pad[4*j+1 +: 3]) & g_pad[4*j]);
        end
    end

    // Each group carry is a flat sum of products over group G/P, not a chain.
    always_comb begin
        logic term;
        logic acc;
        term     = 1'b0;
        acc      = 1'b0;
        grp_c    = '0;
        grp_c[0] = bus.iw_carry;
        for (int j = 1; j <= c_NG; j++) begin
            acc = bus.iw_carry;
            for (int m = 0; m < j; m++) acc = acc & grp_p[m];
            for (int k = 0; k < j; k++) begin
                term = grp_g[k];
                for (int m = k + 1; m < j; m++) term = term & grp_p[m];
                acc = acc | term;
            end
            grp_c[j] = acc;
        end
    end

    always_comb begin
        logic term;
        logic acc;
        int   b;
        term    = 1'b0;
        acc     = 1'b0;
        b       = 0;
        carry_c = '0;
        for (int i = 0; i < p_WIDTH; i++) begin
            b   = (i / 4) * 4;
            acc = grp_c[i/4];
            for (int m = b; m < i; m++) acc = acc & p_pad[m];
            for (int k = b; k < i; k++) begin
                term = g_pad[k];
                for (int m = k + 1; m < i; m++) term = term & p_pad[m];
                acc = acc | term;
            end
            carry_c[i] = acc;
        end
        carry_c[p_WIDTH] = grp_c[c_NG];
    end

    assign output_c = {carry_c[p_WIDTH], p_pad[p_WIDTH-1:0] ^ carry_c[p_WIDTH-1:0]};

    always_comb begin
        valid_d = bus.iw_valid;
        out_d   = bus.iw_valid ? output_c : out_q;
    end

    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

    assign bus.wo_valid   = valid_q;
    assign bus.wov_output = out_q;

`ifdef ADDR_CLA_DEBUG_EN
    logic [p_WIDTH:0]   carry_d, carry_q;
    logic [p_WIDTH:0]   sum_d, sum_q;
    logic [p_WIDTH-1:0] cs_d, cs_q;

    always_comb begin
        carry_d = bus.iw_valid ? carry_c : carry_q;
        sum_d   = bus.iw_valid ? {1'b0, p_pad[p_WIDTH-1:0]} : sum_q;
        cs_d    = bus.iw_valid ? g_pad[p_WIDTH-1:0] : cs_q;
    end

    always_ff @(posedge iw_clk) begin
        if (!iw_rst_n) begin
            carry_q <= '0;
            sum_q   <= '0;
            cs_q    <= '0;
        end else begin
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cs_q    <= cs_d;
        end
    end

    assign bus.wov_carry = carry_q;
    assign bus.wov_sum   = sum_q;
    assign bus.wov_cs    = cs_q;
`else
    assign bus.wov_carry = '0;
    assign bus.wov_sum   = '0;
    assign bus.wov_cs    = '0;
`endif
endmodule

// File: tb/tb_addr_carry_look_ahead.sv
// Bench for addr_carry_look_ahead at widths 2, 5, 8 and 37 against an arithmetic reference model.
// Debug vectors are compared to the model when ADDR_CLA_DEBUG_EN is defined, otherwise to zero.
module tb_addr_carry_look_ahead;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld;
    logic [63:0] x_v;
    logic [63:0] y_v;
    logic        cin;

    int n_checks = 0;
    int n_errors = 0;

    localparam int NI = 4;
    int wid [NI] = '{2, 5, 8, 37};

    logic [63:0] e_out [NI];
    logic [63:0] e_car [NI];
    logic [63:0] e_sum [NI];
    logic [63:0] e_cs  [NI];
    logic        e_v;

    always #5 clk = ~clk;

    addr_carry_look_ahead_if #(.p_WIDTH(2))  if2  ();
    addr_carry_look_ahead_if #(.p_WIDTH(5))  if5  ();
    addr_carry_look_ahead_if #(.p_WIDTH(8))  if8  ();
    addr_carry_look_ahead_if #(.p_WIDTH(37)) if37 ();

    assign if2.iw_valid  = vld;  assign if2.iwv_x  = x_v[1:0];  assign if2.iwv_y  = y_v[1:0];  assign if2.iw_carry  = cin;
    assign if5.iw_valid  = vld;  assign if5.iwv_x  = x_v[4:0];  assign if5.iwv_y  = y_v[4:0];  assign if5.iw_carry  = cin;
    assign if8.iw_valid  = vld;  assign if8.iwv_x  = x_v[7:0];  assign if8.iwv_y  = y_v[7:0];  assign if8.iw_carry  = cin;
    assign if37.iw_valid = vld;  assign if37.iwv_x = x_v[36:0]; assign if37.iwv_y = y_v[36:0]; assign if37.iw_carry = cin;

    addr_carry_look_ahead #(.p_WIDTH(2))  u_dut2  (.iw_clk(clk), .iw_rst_n(rst_n), .bus(if2.slave));
    addr_carry_look_ahead #(.p_WIDTH(5))  u_dut5  (.iw_clk(clk), .iw_rst_n(rst_n), .bus(if5.slave));
    addr_carry_look_ahead #(.p_WIDTH(8))  u_dut8  (.iw_clk(clk), .iw_rst_n(rst_n), .bus(if8.slave));
    addr_carry_look_ahead #(.p_WIDTH(37)) u_dut37 (.iw_clk(clk), .iw_rst_n(rst_n), .bus(if37.slave));

    // Reference: plain integer addition; the carry into bit i is recovered as sum ^ x ^ y.
    initial begin
        e_v = 1'b0;
        for (int n = 0; n < NI; n++) begin
            e_out[n] = '0; e_car[n] = '0; e_sum[n] = '0; e_cs[n] = '0;
        end
    end

    always @(posedge clk) begin
        logic [63:0] mask, xm, ym, full;
        if (!rst_n) begin
            e_v = 1'b0;
            for (int n = 0; n < NI; n++) begin
                e_out[n] = '0; e_car[n] = '0; e_sum[n] = '0; e_cs[n] = '0;
            end
        end else if (vld) begin
            e_v = 1'b1;
            for (int n = 0; n < NI; n++) begin
                mask     = (64'd1 << wid[n]) - 64'd1;
                xm       = x_v & mask;
                ym       = y_v & mask;
                full     = xm + ym + {63'd0, cin};
                e_out[n] = full;
                e_car[n] = full ^ xm ^ ym;
                e_sum[n] = xm ^ ym;
                e_cs[n]  = xm & ym;
            end
        end else begin
            e_v = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input int n, input logic ov, input logic [63:0] oo,
                              input logic [63:0] oc, input logic [63:0] os, input logic [63:0] ocs);
        chk($sformatf("w%0d valid", wid[n]), {63'd0, ov}, {63'd0, e_v});
        chk($sformatf("w%0d output", wid[n]), oo, e_out[n]);
`ifdef ADDR_CLA_DEBUG_EN
        chk($sformatf("w%0d carry", wid[n]), oc, e_car[n]);
        chk($sformatf("w%0d sum", wid[n]), os, e_sum[n]);
        chk($sformatf("w%0d cs", wid[n]), ocs, e_cs[n]);
`else
        chk($sformatf("w%0d carry tied", wid[n]), oc, 64'd0);
        chk($sformatf("w%0d sum tied", wid[n]), os, 64'd0);
        chk($sformatf("w%0d cs tied", wid[n]), ocs, 64'd0);
`endif
    endtask

    task automatic step();
        @(negedge clk);
        check_inst(0, if2.wo_valid,  64'(if2.wov_output),  64'(if2.wov_carry),  64'(if2.wov_sum),  64'(if2.wov_cs));
        check_inst(1, if5.wo_valid,  64'(if5.wov_output),  64'(if5.wov_carry),  64'(if5.wov_sum),  64'(if5.wov_cs));
        check_inst(2, if8.wo_valid,  64'(if8.wov_output),  64'(if8.wov_carry),  64'(if8.wov_sum),  64'(if8.wov_cs));
        check_inst(3, if37.wo_valid, 64'(if37.wov_output), 64'(if37.wov_carry), 64'(if37.wov_sum), 64'(if37.wov_cs));
    endtask

    initial begin
        rst_n = 1'b0; vld = 1'b0; x_v = '0; y_v = '0; cin = 1'b0;
        step();
        step();
        chk("reset output", 64'(if37.wov_output), 64'd0);
        rst_n = 1'b1;

        // Exhaustive 2-bit operands; wider instances see random upper bits.
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < 4; a++)
                for (int b = 0; b < 4; b++) begin
                    x_v = {$urandom, $urandom}; y_v = {$urandom, $urandom};
                    x_v[1:0] = 2'(a); y_v[1:0] = 2'(b); cin = c[0]; vld = 1'b1;
                    step();
                end

        x_v = 64'h3; y_v = 64'h3; cin = 1'b1; vld = 1'b1;
        step();
        chk("w2 11+11+1 output", 64'(if2.wov_output), 64'h7);
`ifdef ADDR_CLA_DEBUG_EN
        chk("w2 11+11+1 carry", 64'(if2.wov_carry), 64'h7);
        chk("w2 11+11+1 sum", 64'(if2.wov_sum), 64'h0);
        chk("w2 11+11+1 cs", 64'(if2.wov_cs), 64'h3);
`endif

        x_v = 64'hFF; y_v = 64'h01; cin = 1'b0;
        step();
        chk("w8 ff+01 output", 64'(if8.wov_output), 64'h100);
`ifdef ADDR_CLA_DEBUG_EN
        chk("w8 ff+01 carry", 64'(if8.wov_carry), 64'h1FE);
`endif

        x_v = 64'hFF; y_v = 64'h00; cin = 1'b1;
        step();
        chk("w8 ff+00+1 output", 64'(if8.wov_output), 64'h100);
`ifdef ADDR_CLA_DEBUG_EN
        chk("w8 ff+00+1 carry", 64'(if8.wov_carry), 64'h1FF);
        chk("w8 ff+00+1 sum", 64'(if8.wov_sum), 64'h0FF);
`endif

        x_v = 64'h16; y_v = 64'h0B; cin = 1'b0;
        step();
        chk("w5 partial output", 64'(if5.wov_output), 64'h21);
`ifdef ADDR_CLA_DEBUG_EN
        chk("w5 partial cs", 64'(if5.wov_cs), 64'h02);
`endif

        // Single valid pulse followed by three idle cycles.
        vld = 1'b0;
        step();
        x_v = {$urandom, $urandom}; y_v = {$urandom, $urandom}; cin = 1'($urandom); vld = 1'b1;
        step();
        chk("pulse valid", {63'd0, if8.wo_valid}, 64'd1);
        vld = 1'b0;
        x_v = {$urandom, $urandom}; y_v = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold valid low", {63'd0, if8.wo_valid}, 64'd0);
        end

        // Reset wins over a simultaneous valid.
        vld = 1'b1; rst_n = 1'b0;
        step();
        chk("reset+valid valid", {63'd0, if37.wo_valid}, 64'd0);
        chk("reset+valid output", 64'(if37.wov_output), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            x_v   = {$urandom, $urandom};
            y_v   = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) x_v = '1;
            if ($urandom_range(0, 7) == 0) y_v = ~x_v;
            cin   = 1'($urandom);
            vld   = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 49) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
